// File: rtl/rans_pkg.sv
// Shared types for the rANS output byte packer: symbol width, byte type and packer FSM states.
package rans_pkg;

   localparam int SYMBOL_WIDTH = 8;

   typedef logic [SYMBOL_WIDTH-1:0] byte_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } packer_state_e;

endpackage

// File: rtl/rans_sync_fifo.sv
// Single-clock FIFO with registered storage; a write into an empty FIFO is visible the next cycle.
module rans_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_rd;
   logic             do_wr;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign do_rd     = rd_en_i && !empty_o;
   // A read in the same cycle frees the slot the write lands in.
   assign do_wr     = wr_en_i && (!full_o || do_rd);
   assign rd_data_o = mem[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (do_wr) mem[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/rans_byte_packer.sv
// Packs 0-2 encoder bytes per cycle densely into OUT_BYTES words behind a valid/ready FIFO.
// Optional byte counter enabled by defining RANS_PACKER_BYTE_COUNT_EN.
module rans_byte_packer
   import rans_pkg::*;
#(
   parameter int OUT_BYTES  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [1:0]                        valid_i,
   input  logic [2*SYMBOL_WIDTH-1:0]         enc_i,
   input  logic                              flush_i,
   output logic [OUT_BYTES*SYMBOL_WIDTH-1:0] out_data_o,
   output logic [OUT_BYTES-1:0]              out_keep_o,
   output logic                              out_last_o,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              overflow_o,
   output logic [31:0]                       byte_cnt_o,
   output packer_state_e                     state_o
);

   // Stream handshake: a word moves when out_valid_o && out_ready_i at a rising clk_i;
   // data/keep/last hold steady while valid is high and ready is low.
   localparam int SW = SYMBOL_WIDTH;
   localparam int DW = OUT_BYTES*SW;
   localparam int FW = DW + OUT_BYTES + 1;
   localparam int TW = $clog2(OUT_BYTES+2);

   packer_state_e          state_q, state_d;
   byte_t [OUT_BYTES-1:0]  acc_q, acc_d;
   logic  [TW-1:0]         cnt_q, cnt_d;
   logic                   overflow_q, overflow_d;
   byte_t [OUT_BYTES:0]    merged;
   byte_t [OUT_BYTES-1:0]  flush_data;
   logic  [OUT_BYTES-1:0]  flush_keep;
   logic  [TW-1:0]         n_new, total;
   byte_t                  b0, b1;
   logic                   push, pop, can_push, done;
   logic  [FW-1:0]         push_word, head;
   logic                   fifo_full, fifo_empty;

   assign pop      = !fifo_empty && out_ready_i;
   assign can_push = !fifo_full || pop;
   assign done     = (state_q == ST_DRAIN) && pop && head[FW-1];

   always_comb begin
      b0    = valid_i[0] ? enc_i[SW-1:0] : enc_i[2*SW-1:SW];
      b1    = enc_i[2*SW-1:SW];
      n_new = TW'(valid_i[0]) + TW'(valid_i[1]);
      total = cnt_q + n_new;
      // New bytes land right after the held ones; lane OUT_BYTES is the carry into the next word.
      for (int i = 0; i < OUT_BYTES; i++) begin
         merged[i] = '0;
         if (TW'(i) < cnt_q)                                   merged[i] = acc_q[i];
         else if (TW'(i) == cnt_q && n_new != '0)               merged[i] = b0;
         else if (TW'(i) == cnt_q + TW'(1) && n_new == TW'(2))  merged[i] = b1;
         flush_keep[i] = (TW'(i) < cnt_q);
         flush_data[i] = flush_keep[i] ? acc_q[i] : '0;
      end
      merged[OUT_BYTES] = (cnt_q == TW'(OUT_BYTES-1) && n_new == TW'(2)) ? b1 : '0;
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      push       = 1'b0;
      push_word  = '0;
      case (state_q)
         ST_RUN: begin
            if (total >= TW'(OUT_BYTES)) begin
               push      = can_push;
               push_word = {1'b0, {OUT_BYTES{1'b1}}, merged[OUT_BYTES-1:0]};
               if (!can_push) overflow_d = 1'b1;
               acc_d     = '0;
               acc_d[0]  = merged[OUT_BYTES];
               cnt_d     = total - TW'(OUT_BYTES);
            end else begin
               acc_d = merged[OUT_BYTES-1:0];
               cnt_d = total;
            end
            if (flush_i) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (valid_i != 2'b00) overflow_d = 1'b1;
            if (can_push) begin
               push      = 1'b1;
               push_word = {1'b1, flush_keep, flush_data};
               acc_d     = '0;
               cnt_d     = '0;
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (valid_i != 2'b00) overflow_d = 1'b1;
            if (done) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         acc_q      <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   rans_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push),
      .wr_data_i (push_word),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

`ifdef RANS_PACKER_BYTE_COUNT_EN
   logic [31:0] byte_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_cnt_q <= '0;
      end else if (done) begin
         byte_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         if (byte_cnt_q > 32'hFFFF_FFFF - 32'(n_new)) byte_cnt_q <= 32'hFFFF_FFFF;
         else                                          byte_cnt_q <= byte_cnt_q + 32'(n_new);
      end
   end

   assign byte_cnt_o = byte_cnt_q;
`else
   assign byte_cnt_o = '0;
`endif

   // Storage is not reset, so the stream fields are forced to zero whenever no word is offered.
   assign out_valid_o = !fifo_empty;
   assign out_data_o  = out_valid_o ? head[DW-1:0] : '0;
   assign out_keep_o  = out_valid_o ? head[FW-2:DW] : '0;
   assign out_last_o  = out_valid_o && head[FW-1];
   assign busy_o      = (state_q != ST_RUN);
   assign done_o      = done;
   assign overflow_o  = overflow_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_rans_byte_packer.sv
// Directed bench for rans_byte_packer: hand-computed words, flush framing, overflow and reset.
module tb_rans_byte_packer;
   import rans_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [1:0]    valid_i = '0;
   logic [15:0]   enc_i = '0;
   logic          flush_i = 1'b0;
   logic [31:0]   out_data_o;
   logic [3:0]    out_keep_o;
   logic          out_last_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic          busy_o;
   logic          done_o;
   logic          overflow_o;
   logic [31:0]   byte_cnt_o;
   packer_state_e state_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   rans_byte_packer #(.OUT_BYTES(4), .FIFO_DEPTH(16)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .enc_i       (enc_i),
      .flush_i     (flush_i),
      .out_data_o  (out_data_o),
      .out_keep_o  (out_keep_o),
      .out_last_o  (out_last_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .overflow_o  (overflow_o),
      .byte_cnt_o  (byte_cnt_o),
      .state_o     (state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One input cycle; returns 1 time unit after the sampling edge.
   task automatic cyc(input logic [1:0] v, input logic [15:0] e, input logic f);
      valid_i = v;
      enc_i   = e;
      flush_i = f;
      @(posedge clk_i);
      #1;
      valid_i = '0;
      enc_i   = '0;
      flush_i = 1'b0;
   endtask

   task automatic cnt_chk(input string tag, input logic [31:0] exp_en);
`ifdef RANS_PACKER_BYTE_COUNT_EN
      chk(tag, byte_cnt_o, exp_en);
`else
      chk(tag, byte_cnt_o, 32'h0 & exp_en);
`endif
   endtask

   task automatic read_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input logic dn);
      int t = 0;
      while (!out_valid_o && t < 20) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      chk({tag, "_valid"}, 32'(out_valid_o), 32'h1);
      chk({tag, "_data"},  out_data_o, d);
      chk({tag, "_keep"},  32'(out_keep_o), 32'(k));
      chk({tag, "_last"},  32'(out_last_o), 32'(l));
      out_ready_i = 1'b1;
      #1;
      chk({tag, "_done"},  32'(done_o), 32'(dn));
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_valid",    32'(out_valid_o), 32'h0);
      chk("rst_data",     out_data_o, 32'h0);
      chk("rst_busy",     32'(busy_o), 32'h0);
      chk("rst_done",     32'(done_o), 32'h0);
      chk("rst_overflow", 32'(overflow_o), 32'h0);
      chk("rst_bytecnt",  byte_cnt_o, 32'h0);
      chk("rst_state",    32'(state_o), 32'(ST_RUN));
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // T1: four single low-lane bytes make one word; valid the cycle after the 4th edge
      cyc(2'b01, 16'h0011, 1'b0);
      cyc(2'b01, 16'h0022, 1'b0);
      cyc(2'b01, 16'h0033, 1'b0);
      chk("t1_not_yet", 32'(out_valid_o), 32'h0);
      cyc(2'b01, 16'h0044, 1'b0);
      chk("t1_latency", 32'(out_valid_o), 32'h1);
      read_word("t1_w0", 32'h4433_2211, 4'hF, 1'b0, 1'b0);
      chk("t1_empty", 32'(out_valid_o), 32'h0);
      cnt_chk("t1_bytecnt", 32'd4);

      // T2: flush on the cycle that fills the word exactly -> extra all-zero-keep last word
      cyc(2'b11, 16'hBBAA, 1'b0);
      cyc(2'b11, 16'hDDCC, 1'b1);
      chk("t2_busy",  32'(busy_o), 32'h1);
      chk("t2_state", 32'(state_o), 32'(ST_FLUSH));
      cnt_chk("t2_bytecnt", 32'd8);
      read_word("t2_w0", 32'hDDCC_BBAA, 4'hF, 1'b0, 1'b0);
      chk("t2_drain", 32'(state_o), 32'(ST_DRAIN));
      read_word("t2_w1", 32'h0000_0000, 4'h0, 1'b1, 1'b1);
      chk("t2_done_pulse", 32'(done_o), 32'h0);
      chk("t2_idle",       32'(busy_o), 32'h0);
      cnt_chk("t2_cnt_clr", 32'd0);

      // T3: partial word flushed with keep=7
      cyc(2'b01, 16'h0001, 1'b0);
      cyc(2'b01, 16'h0002, 1'b0);
      cyc(2'b01, 16'h0003, 1'b0);
      cyc(2'b00, 16'h0000, 1'b1);
      cnt_chk("t3_bytecnt", 32'd3);
      read_word("t3_w0", 32'h0003_0201, 4'h7, 1'b1, 1'b1);
      chk("t3_overflow", 32'(overflow_o), 32'h0);

      // T5: high-lane singles, low-lane singles and pairs crossing word boundaries
      cyc(2'b10, 16'hA100, 1'b0);
      cyc(2'b01, 16'h00A2, 1'b0);
      cyc(2'b10, 16'hA300, 1'b0);
      cyc(2'b01, 16'h00A4, 1'b0);
      cyc(2'b10, 16'hA500, 1'b0);
      cyc(2'b11, 16'hA7A6, 1'b0);
      cyc(2'b11, 16'hA9A8, 1'b0);
      cyc(2'b01, 16'h00AA, 1'b1);
      cnt_chk("t5_bytecnt", 32'd10);
      read_word("t5_w0", 32'hA4A3_A2A1, 4'hF, 1'b0, 1'b0);
      read_word("t5_w1", 32'hA8A7_A6A5, 4'hF, 1'b0, 1'b0);
      read_word("t5_w2", 32'h0000_AAA9, 4'h3, 1'b1, 1'b1);
      chk("t5_overflow", 32'(overflow_o), 32'h0);

      // T6: bytes during FLUSH are dropped; reset in DRAIN with two words queued
      cyc(2'b11, 16'h5150, 1'b0);
      cyc(2'b11, 16'h5352, 1'b0);
      cyc(2'b11, 16'h5554, 1'b1);
      cyc(2'b01, 16'h0056, 1'b0);
      chk("t6_drop_ovf", 32'(overflow_o), 32'h1);
      chk("t6_drain",    32'(state_o), 32'(ST_DRAIN));
      chk("t6_head",     out_data_o, 32'h5352_5150);
      out_ready_i = 1'b1;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(out_valid_o), 32'h0);
      chk("t6_rst_done",  32'(done_o), 32'h0);
      chk("t6_rst_busy",  32'(busy_o), 32'h0);
      chk("t6_rst_state", 32'(state_o), 32'(ST_RUN));
      chk("t6_rst_ovf",   32'(overflow_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("t6_post_valid", 32'(out_valid_o), 32'h0);
      chk("t6_post_data",  out_data_o, 32'h0);
      out_ready_i = 1'b0;

      // T4: 17 words into a 16-deep FIFO with no reads -> last word dropped
      for (int k = 0; k < 17; k++) begin
         logic [7:0] b;
         b = 8'(k*4);
         if (k == 16) chk("t4_no_ovf_yet", 32'(overflow_o), 32'h0);
         cyc(2'b11, {b + 8'd1, b}, 1'b0);
         cyc(2'b11, {b + 8'd3, b + 8'd2}, 1'b0);
         if (k < 16) exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      chk("t4_overflow", 32'(overflow_o), 32'h1);
      for (int k = 0; k < 16; k++) begin
         logic [31:0] w;
         w = exp_q.pop_front();
         read_word($sformatf("t4_w%0d", k), w, 4'hF, 1'b0, 1'b0);
      end
      chk("t4_drained", 32'(out_valid_o), 32'h0);
      chk("t4_sticky",  32'(overflow_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
